// File: rtl/gray_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gray_counter                                               |
// | Brief   : Up/down binary counter with registered Gray-coded output,  |
// |           optional modular wrap or saturation at the count limits.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gray_counter #(
  parameter int WIDTH   = 4,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             at_max, at_zero;

  assign at_max  = &bin_q;
  assign at_zero = ~|bin_q;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    if (clr) begin
      bin_d = '0;
      sat_d = 1'b0;
    end else if (load) begin
      bin_d = load_val;
      sat_d = 1'b0;
    end else if (en) begin
      if (up) begin
        if (at_max && !WRAP_EN) begin
          sat_d = 1'b1;
        end else begin
          bin_d  = bin_q + c_one;
          wrap_d = at_max;
          sat_d  = 1'b0;
        end
      end else begin
        if (at_zero && !WRAP_EN) begin
          sat_d = 1'b1;
        end else begin
          bin_d  = bin_q - c_one;
          wrap_d = at_zero;
          sat_d  = 1'b0;
        end
      end
    end
    // Encode from next-state so Gray and binary update on the same edge.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;
  assign sat      = sat_q;

endmodule
`default_nettype wire

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Registered up/down counter that produces a Gray-coded count for converter_gray_bin and other Gray consumers (pointer logic, position encoders).
- Keeps a binary state register and a registered Gray output, so only one bit changes per step.
- Sits directly upstream of converter_gray_bin. In the system bench, `gray_out` drives the converter's `gray_in`, and the converter's `bin_out` must equal this block's `bin_out`.

Parameters:
- WIDTH, 4, counter and code width in bits (legal range 2..32).
- WRAP_EN, 1, 1 = modular wrap at both ends; 0 = saturate at max/zero.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear to zero.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  binary value to load.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- gray_out  output  WIDTH  registered Gray code of the current count.
- bin_out  output  WIDTH  registered binary count.
- wrap  output  1  one-cycle pulse when the count wraps.
- sat  output  1  level; high while the count is held at a saturation limit (WRAP_EN=0 only).

Behaviour:
- Reset:
  - While rst=1: bin_out=0, gray_out=0, wrap=0, sat=0, immediately and independent of clk.
  - Release is taken synchronously. The first update happens on the first rising edge with rst=0.
- Priority each edge: clr > load > en > hold.
  - clr=1: bin=0, gray=0, wrap=0, sat=0.
  - load=1: bin=load_val, gray=load_val ^ (load_val>>1), wrap=0, sat=0. Loaded values are never clamped.
  - en=1, up=1: next=bin+1 mod 2^WIDTH.
  - en=1, up=0: next=bin-1 mod 2^WIDTH.
  - en=0: all registers hold, wrap=0; sat holds its value.
- Gray encoding:
  - gray_out is always bin_out ^ (bin_out>>1) at every visible cycle.
  - It is computed from next-bin and registered on the same edge as bin_out. There is no extra cycle of Gray lag.
  - Latency: en sampled at edge N; new count visible after edge N.
- Wrap, WRAP_EN=1:
  - Up from 2^WIDTH-1 goes to 0; down from 0 goes to 2^WIDTH-1.
  - wrap=1 for exactly the cycle in which the wrapped value is displayed; otherwise 0.
- Saturate, WRAP_EN=0:
  - Up at 2^WIDTH-1 holds the count and sets sat=1.
  - Down at 0 holds the count and sets sat=1.
  - wrap is tied to 0.
  - sat clears on any edge where the count changes, or on clr, load or rst.
  - While at a limit, en=1 in the opposite direction moves the count and clears sat on that edge.
- Single-bit property:
  - Every en-driven step changes exactly one bit of gray_out, including wrap steps.
  - load and clr are exempt.
- Direction changes mid-count take effect on the same edge; no turnaround cycle.
- Reset mid-operation:
  - Asynchronous assertion overrides any pending clr, load or en.
  - No wrap pulse may appear on the reset edge or the first edge after release.
- X-safety: with rst=1, outputs must be 0 even if clr, load, en, up or load_val are X.

Test Plan:
- Reset: rst=1 with en=1 and load=1 toggling, no clock edge → bin_out=0, gray_out=0, wrap=0, sat=0 immediately; first edge after release with en=1, up=1 → bin_out=1, gray_out=0001.
- Up sequence (WIDTH=4): en=1, up=1 for 16 edges from 0 →
  - gray_out = 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - wrap=1 only on the 0000 cycle.
  - Each step has Hamming distance 1.
  - converter_gray_bin output equals bin_out every cycle.
- Down from zero: clr, then en=1, up=0 → bin_out=15, gray_out=1000, wrap=1 for one cycle; next edge → bin_out=14, gray_out=1001, wrap=0.
- Priority:
  - load=1, load_val=9, en=1, up=1 → bin_out=9, gray_out=1101, no increment.
  - Same edge with clr=1 added → bin_out=0, gray_out=0000.
- Saturate (WRAP_EN=0): load 14, en=1, up=1 for 3 edges → bin_out 15, 15, 15; gray_out 1000; sat=0, 1, 1; wrap=0. Then up=0 for 1 edge → bin_out=14, sat=0.
- Async reset mid-count: at bin_out=6 (gray 0101), assert rst between edges → outputs 0 before the next edge; hold rst for 2 edges, release → counting resumes 1, 2, … with no wrap pulse.
